// File: rtl/ariane_soc_pkg.sv
// SoC-wide constants for the CLINT port: address map, register offsets,
// AXI-Lite response codes, FSM state types and the CLINT address decoder.
package ariane_soc;

   localparam logic [63:0] CLINTBase           = 64'h0000_0000_0200_0000;
   localparam logic [63:0] CLINTLength         = 64'h0000_0000_000C_0000;
   localparam logic [19:0] ClintMsipOffset     = 20'h0_0000;
   localparam logic [19:0] ClintMtimecmpOffset = 20'h0_4000;
   localparam logic [19:0] ClintMtimeOffset    = 20'h0_BFF8;

   localparam logic [1:0] AxiRespOkay   = 2'b00;
   localparam logic [1:0] AxiRespSlvErr = 2'b10;

   typedef enum logic {W_IDLE, W_RESP} w_state_e;
   typedef enum logic {R_IDLE, R_DATA} r_state_e;

   typedef enum logic [1:0] {REG_NONE, REG_MSIP, REG_MTIMECMP, REG_MTIME} clint_reg_e;

   typedef struct packed {
      clint_reg_e kind;
      logic [2:0] idx;
   } clint_dec_t;

   // word = addr[19:2]; the subtractions wrap so offsets below a block base miss.
   function automatic clint_dec_t clint_decode(input logic [17:0] word, input int unsigned nr_harts);
      logic [17:0] msip_w;
      logic [16:0] cmp_dw;
      clint_dec_t  dec;
      msip_w = word - ClintMsipOffset[19:2];
      cmp_dw = word[17:1] - ClintMtimecmpOffset[19:3];
      dec    = '{kind: REG_NONE, idx: 3'd0};
      if (32'(msip_w) < nr_harts) begin
         dec = '{kind: REG_MSIP, idx: msip_w[2:0]};
      end else if (32'(cmp_dw) < nr_harts) begin
         dec = '{kind: REG_MTIMECMP, idx: cmp_dw[2:0]};
      end else if (word[17:1] == ClintMtimeOffset[19:3]) begin
         dec = '{kind: REG_MTIME, idx: 3'd0};
      end
      return dec;
   endfunction

   function automatic logic [63:0] strb_merge(input logic [63:0] old_d, input logic [63:0] new_d,
                                              input logic [7:0] strb);
      logic [63:0] res;
      for (int b = 0; b < 8; b++) begin
         res[8*b +: 8] = strb[b] ? new_d[8*b +: 8] : old_d[8*b +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/clint_axil_slave_rtc_edge.sv
// rtc rising-edge detector producing a one-cycle tick. With CLINT_RTC_SYNC_EN
// defined, rtc_i is treated as asynchronous and passes a 2-flop synchronizer first.
module clint_rtc_edge (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic rtc_i,
   output logic tick
);

`ifdef CLINT_RTC_SYNC_EN
   logic [1:0] rtc_sync;
   logic       rtc_q;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         rtc_sync <= 2'b00;
         rtc_q    <= 1'b0;
      end else begin
         rtc_sync <= {rtc_sync[0], rtc_i};
         rtc_q    <= rtc_sync[1];
      end
   end

   assign tick = rtc_sync[1] & ~rtc_q;
`else
   logic rtc_q;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) rtc_q <= 1'b0;
      else         rtc_q <= rtc_i;
   end

   assign tick = rtc_i & ~rtc_q;
`endif

endmodule

// File: rtl/clint_axil_slave.sv
// CLINT AXI4-Lite responder: per-hart msip/mtimecmp, global mtime, ipi/timer irqs.
// Optional macro CLINT_RTC_SYNC_EN synchronizes an asynchronous rtc_i.
module clint_axil_slave
   import ariane_soc::*;
#(
   parameter int unsigned NR_HARTS = 1,
   parameter int unsigned ADDR_W   = 64
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                rtc_i,
   input  logic [ADDR_W-1:0]   aw_addr_i,
   input  logic                aw_valid_i,
   output logic                aw_ready_o,
   input  logic [63:0]         w_data_i,
   input  logic [7:0]          w_strb_i,
   input  logic                w_valid_i,
   output logic                w_ready_o,
   output logic [1:0]          b_resp_o,
   output logic                b_valid_o,
   input  logic                b_ready_i,
   input  logic [ADDR_W-1:0]   ar_addr_i,
   input  logic                ar_valid_i,
   output logic                ar_ready_o,
   output logic [63:0]         r_data_o,
   output logic [1:0]          r_resp_o,
   output logic                r_valid_o,
   input  logic                r_ready_i,
   output logic [NR_HARTS-1:0] timer_irq_o,
   output logic [NR_HARTS-1:0] ipi_o
);

   w_state_e w_state, w_state_nx;
   r_state_e r_state, r_state_nx;
   logic     w_acc, r_acc, tick;

   logic [NR_HARTS-1:0]       msip;
   logic [NR_HARTS-1:0][63:0] mtimecmp;
   logic [63:0]               mtime, mtime_inc, rd_val;
   clint_dec_t                wdec, rdec;

   logic unused_addr;
   assign unused_addr = ^{aw_addr_i[ADDR_W-1:20], aw_addr_i[1:0], ar_addr_i[ADDR_W-1:20], ar_addr_i[1:0]};

   clint_rtc_edge u_rtc_edge (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .rtc_i  (rtc_i),
      .tick   (tick)
   );

   assign wdec      = clint_decode(aw_addr_i[19:2], NR_HARTS);
   assign rdec      = clint_decode(ar_addr_i[19:2], NR_HARTS);
   assign mtime_inc = mtime + 64'(tick);

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         w_state <= W_IDLE;
         r_state <= R_IDLE;
      end else begin
         w_state <= w_state_nx;
         r_state <= r_state_nx;
      end
   end

   // Readies are masked by reset so no handshake is advertised while in reset.
   always_comb begin
      w_state_nx = w_state;
      aw_ready_o = 1'b0;
      w_ready_o  = 1'b0;
      b_valid_o  = 1'b0;
      w_acc      = 1'b0;
      case (w_state)
         W_IDLE: begin
            w_acc      = rst_ni & aw_valid_i & w_valid_i;
            aw_ready_o = w_acc;
            w_ready_o  = w_acc;
            if (w_acc) w_state_nx = W_RESP;
         end
         W_RESP: begin
            b_valid_o = 1'b1;
            if (b_ready_i) w_state_nx = W_IDLE;
         end
         default: w_state_nx = W_IDLE;
      endcase
   end

   always_comb begin
      r_state_nx = r_state;
      ar_ready_o = 1'b0;
      r_valid_o  = 1'b0;
      r_acc      = 1'b0;
      case (r_state)
         R_IDLE: begin
            r_acc      = rst_ni & ar_valid_i;
            ar_ready_o = r_acc;
            if (r_acc) r_state_nx = R_DATA;
         end
         R_DATA: begin
            r_valid_o = 1'b1;
            if (r_ready_i) r_state_nx = R_IDLE;
         end
         default: r_state_nx = R_IDLE;
      endcase
   end

   always_comb begin
      rd_val = 64'h0;
      for (int h = 0; h < NR_HARTS; h++) begin
         if (rdec.idx == 3'(h)) begin
            if (rdec.kind == REG_MSIP)
               rd_val = ar_addr_i[2] ? {31'b0, msip[h], 32'b0} : {63'b0, msip[h]};
            else if (rdec.kind == REG_MTIMECMP)
               rd_val = mtimecmp[h];
         end
      end
      if (rdec.kind == REG_MTIME) rd_val = mtime;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         b_resp_o <= AxiRespOkay;
         r_resp_o <= AxiRespOkay;
         r_data_o <= 64'h0;
      end else begin
         if (w_acc) b_resp_o <= (wdec.kind == REG_NONE) ? AxiRespSlvErr : AxiRespOkay;
         if (r_acc) begin
            r_resp_o <= (rdec.kind == REG_NONE) ? AxiRespSlvErr : AxiRespOkay;
            r_data_o <= rd_val;
         end
      end
   end

   // Written mtime bytes override the tick; unwritten bytes keep the increment.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         msip     <= '0;
         mtimecmp <= '1;
         mtime    <= 64'h0;
      end else begin
         mtime <= (w_acc && wdec.kind == REG_MTIME) ? strb_merge(mtime_inc, w_data_i, w_strb_i) : mtime_inc;
         for (int h = 0; h < NR_HARTS; h++) begin
            if (w_acc && wdec.idx == 3'(h)) begin
               if (wdec.kind == REG_MSIP && (aw_addr_i[2] ? w_strb_i[4] : w_strb_i[0]))
                  msip[h] <= aw_addr_i[2] ? w_data_i[32] : w_data_i[0];
               if (wdec.kind == REG_MTIMECMP)
                  mtimecmp[h] <= strb_merge(mtimecmp[h], w_data_i, w_strb_i);
            end
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         timer_irq_o <= '0;
         ipi_o       <= '0;
      end else begin
         for (int h = 0; h < NR_HARTS; h++) timer_irq_o[h] <= (mtime >= mtimecmp[h]);
         ipi_o <= msip;
      end
   end

endmodule

// File: tb/tb_clint_axil_slave.sv
// Scoreboard bench for clint_axil_slave: expected responses are queued when a
// transaction is issued and popped when the DUT answers.
module tb_clint_axil_slave;

   localparam int          NR_HARTS = 1;
   localparam logic [1:0]  OKAY     = 2'b00;
   localparam logic [1:0]  SLVERR   = 2'b10;
   localparam logic [63:0] BASE     = 64'h0000_0000_0200_0000;
   localparam logic [63:0] ONES     = 64'hFFFF_FFFF_FFFF_FFFF;
`ifdef CLINT_RTC_SYNC_EN
   localparam int RTC_LEAD = 2;
`else
   localparam int RTC_LEAD = 0;
`endif

   logic clk = 1'b0;
   logic rst_n, rtc;
   logic [63:0] aw_addr, ar_addr, w_data, r_data;
   logic [7:0]  w_strb;
   logic aw_valid, aw_ready, w_valid, w_ready, b_valid, b_ready;
   logic ar_valid, ar_ready, r_valid, r_ready;
   logic [1:0] b_resp, r_resp;
   logic [NR_HARTS-1:0] timer_irq, ipi;

   typedef struct {
      logic [1:0]  resp;
      logic [63:0] data;
   } exp_t;
   exp_t exp_q[$];

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   clint_axil_slave #(.NR_HARTS(NR_HARTS), .ADDR_W(64)) dut (
      .clk_i(clk), .rst_ni(rst_n), .rtc_i(rtc),
      .aw_addr_i(aw_addr), .aw_valid_i(aw_valid), .aw_ready_o(aw_ready),
      .w_data_i(w_data), .w_strb_i(w_strb), .w_valid_i(w_valid), .w_ready_o(w_ready),
      .b_resp_o(b_resp), .b_valid_o(b_valid), .b_ready_i(b_ready),
      .ar_addr_i(ar_addr), .ar_valid_i(ar_valid), .ar_ready_o(ar_ready),
      .r_data_o(r_data), .r_resp_o(r_resp), .r_valid_o(r_valid), .r_ready_i(r_ready),
      .timer_irq_o(timer_irq), .ipi_o(ipi)
   );

   task automatic do_write(input logic [63:0] addr, input logic [63:0] data, input logic [7:0] strb,
                           output logic [1:0] resp, output bit ok);
      int cnt;
      cnt = 0;
      @(negedge clk);
      aw_addr = addr; w_data = data; w_strb = strb; aw_valid = 1'b1; w_valid = 1'b1;
      #1;
      while (!(aw_ready && w_ready) && cnt < 20) begin
         @(negedge clk); #1; cnt++;
      end
      ok = (cnt < 20);
      @(posedge clk); #1;
      aw_valid = 1'b0; w_valid = 1'b0;
      @(negedge clk);
      ok   = ok && (b_valid === 1'b1);
      resp = b_resp;
   endtask

   task automatic do_read(input logic [63:0] addr, output logic [1:0] resp, output logic [63:0] data,
                          output bit ok);
      int cnt;
      cnt = 0;
      @(negedge clk);
      ar_addr = addr; ar_valid = 1'b1;
      #1;
      while (!ar_ready && cnt < 20) begin
         @(negedge clk); #1; cnt++;
      end
      ok = (cnt < 20);
      @(posedge clk); #1;
      ar_valid = 1'b0;
      @(negedge clk);
      ok   = ok && (r_valid === 1'b1);
      resp = r_resp;
      data = r_data;
   endtask

   task automatic rtc_pulse;
      @(posedge clk); #1 rtc = 1'b1;
      repeat (3) @(posedge clk);
      #1 rtc = 1'b0;
      repeat (5) @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      logic [1:0] resp; logic [63:0] data; bit ok; exp_t e;
      rst_n = 1'b0;
      aw_valid = 1'b1; w_valid = 1'b1; ar_valid = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if ({aw_ready, w_ready, ar_ready, b_valid, r_valid} !== 5'b0) begin
         n_err++; $display("FAIL reset_handshake: got %b want 00000", {aw_ready, w_ready, ar_ready, b_valid, r_valid});
      end
      n_cmp++;
      if (b_resp !== 2'b0 || r_resp !== 2'b0 || r_data !== 64'h0) begin
         n_err++; $display("FAIL reset_resp: got b=%0d r=%0d data=%h want 0 0 0", b_resp, r_resp, r_data);
      end
      n_cmp++;
      if (timer_irq !== '0 || ipi !== '0) begin
         n_err++; $display("FAIL reset_irq: got timer=%b ipi=%b want 0 0", timer_irq, ipi);
      end
      aw_valid = 1'b0; w_valid = 1'b0; ar_valid = 1'b0;
      @(posedge clk); #1 rst_n = 1'b1;
      exp_q.push_back('{OKAY, ONES});
      do_read(BASE + 64'h4000, resp, data, ok);
      e = exp_q.pop_front();
      n_cmp++;
      if (!ok || resp !== e.resp || data !== e.data) begin
         n_err++; $display("FAIL reset_mtimecmp: got ok=%0d resp=%0d data=%h want resp=%0d data=%h", ok, resp, data, e.resp, e.data);
      end
      n_cmp++;
      if (timer_irq !== '0) begin
         n_err++; $display("FAIL reset_timer_irq: got %b want 0", timer_irq);
      end
   endtask

   task automatic test_msip;
      logic [1:0] resp; logic [63:0] data; bit ok; exp_t e;
      exp_q.push_back('{OKAY, 64'h0});
      do_write(BASE, 64'h1, 8'h0F, resp, ok);
      e = exp_q.pop_front();
      n_cmp++;
      if (!ok || resp !== e.resp) begin
         n_err++; $display("FAIL msip_wr_resp: got ok=%0d resp=%0d want resp=%0d", ok, resp, e.resp);
      end
      n_cmp++;
      if (ipi[0] !== 1'b0) begin
         n_err++; $display("FAIL msip_ipi_early: got %b want 0 at T+1", ipi[0]);
      end
      @(negedge clk);
      n_cmp++;
      if (ipi[0] !== 1'b1) begin
         n_err++; $display("FAIL msip_ipi_t2: got %b want 1 at T+2", ipi[0]);
      end
      exp_q.push_back('{OKAY, 64'h0});
      do_write(BASE, 64'h0, 8'hF0, resp, ok);
      e = exp_q.pop_front();
      n_cmp++;
      if (!ok || resp !== e.resp) begin
         n_err++; $display("FAIL msip_wr_nostrb: got ok=%0d resp=%0d want resp=%0d", ok, resp, e.resp);
      end
      exp_q.push_back('{OKAY, 64'h1});
      do_read(BASE, resp, data, ok);
      e = exp_q.pop_front();
      n_cmp++;
      if (!ok || resp !== e.resp || data !== e.data) begin
         n_err++; $display("FAIL msip_rd: got ok=%0d resp=%0d data=%h want resp=%0d data=%h", ok, resp, data, e.resp, e.data);
      end
   endtask

   task automatic test_timer;
      logic [1:0] resp; logic [63:0] data; bit ok; exp_t e;
      exp_q.push_back('{OKAY, 64'h0});
      do_write(BASE + 64'h4000, 64'd5, 8'hFF, resp, ok);
      e = exp_q.pop_front();
      n_cmp++;
      if (!ok || resp !== e.resp) begin
         n_err++; $display("FAIL cmp5_wr: got ok=%0d resp=%0d want resp=%0d", ok, resp, e.resp);
      end
      for (int i = 1; i <= 5; i++) begin
         rtc_pulse();
         if (i == 4) begin
            n_cmp++;
            if (timer_irq[0] !== 1'b0) begin
               n_err++; $display("FAIL timer_irq_at4: got %b want 0", timer_irq[0]);
            end
         end
      end
      n_cmp++;
      if (timer_irq[0] !== 1'b1) begin
         n_err++; $display("FAIL timer_irq_at5: got %b want 1", timer_irq[0]);
      end
      exp_q.push_back('{OKAY, 64'd5});
      do_read(BASE + 64'hBFF8, resp, data, ok);
      e = exp_q.pop_front();
      n_cmp++;
      if (!ok || resp !== e.resp || data !== e.data) begin
         n_err++; $display("FAIL mtime_rd5: got ok=%0d resp=%0d data=%h want resp=%0d data=%h", ok, resp, data, e.resp, e.data);
      end
      exp_q.push_back('{OKAY, 64'h0});
      do_write(BASE + 64'h4000, 64'd100, 8'hFF, resp, ok);
      e = exp_q.pop_front();
      n_cmp++;
      if (!ok || resp !== e.resp || timer_irq[0] !== 1'b1) begin
         n_err++; $display("FAIL cmp100_wr: got ok=%0d resp=%0d irq=%b want resp=%0d irq=1", ok, resp, timer_irq[0], e.resp);
      end
      @(negedge clk);
      n_cmp++;
      if (timer_irq[0] !== 1'b0) begin
         n_err++; $display("FAIL timer_irq_fall: got %b want 0", timer_irq[0]);
      end
   endtask

   task automatic test_mtime;
      logic [1:0] resp; logic [63:0] data; bit ok; exp_t e;
      exp_q.push_back('{OKAY, 64'h0});
      do_write(BASE + 64'hBFF8, ONES, 8'hFF, resp, ok);
      e = exp_q.pop_front();
      rtc_pulse();
      exp_q.push_back('{OKAY, 64'h0});
      do_read(BASE + 64'hBFF8, resp, data, ok);
      e = exp_q.pop_front();
      n_cmp++;
      if (!ok || resp !== e.resp || data !== e.data || timer_irq[0] !== 1'b0) begin
         n_err++; $display("FAIL mtime_wrap: got ok=%0d resp=%0d data=%h irq=%b want data=%h irq=0", ok, resp, data, timer_irq[0], e.data);
      end
      @(posedge clk); #1 rtc = 1'b1;
      repeat (RTC_LEAD) begin
         @(posedge clk); #1;
      end
      aw_addr = BASE + 64'hBFF8; w_data = 64'h1234; w_strb = 8'hFF;
      aw_valid = 1'b1; w_valid = 1'b1;
      exp_q.push_back('{OKAY, 64'h0});
      #1;
      n_cmp++;
      if (aw_ready !== 1'b1) begin
         n_err++; $display("FAIL tick_wr_accept: got %b want 1", aw_ready);
      end
      @(posedge clk); #1;
      aw_valid = 1'b0; w_valid = 1'b0;
      @(negedge clk);
      e = exp_q.pop_front();
      n_cmp++;
      if (b_valid !== 1'b1 || b_resp !== e.resp) begin
         n_err++; $display("FAIL tick_wr_b: got valid=%b resp=%0d want 1 %0d", b_valid, b_resp, e.resp);
      end
      repeat (3) @(posedge clk);
      #1 rtc = 1'b0;
      repeat (3) @(posedge clk);
      exp_q.push_back('{OKAY, 64'h1234});
      do_read(BASE + 64'hBFF8, resp, data, ok);
      e = exp_q.pop_front();
      n_cmp++;
      if (!ok || resp !== e.resp || data !== e.data) begin
         n_err++; $display("FAIL tick_wr_wins: got ok=%0d resp=%0d data=%h want data=%h", ok, resp, data, e.data);
      end
      exp_q.push_back('{OKAY, 64'h0});
      do_write(BASE + 64'hBFF8, 64'hFFFF_FFFF_FFFF_FFAB, 8'h01, resp, ok);
      e = exp_q.pop_front();
      exp_q.push_back('{OKAY, 64'h12AB});
      do_read(BASE + 64'hBFF8, resp, data, ok);
      e = exp_q.pop_front();
      n_cmp++;
      if (!ok || resp !== e.resp || data !== e.data) begin
         n_err++; $display("FAIL mtime_strb: got ok=%0d resp=%0d data=%h want data=%h", ok, resp, data, e.data);
      end
   endtask

   task automatic test_slverr;
      logic [1:0] resp; logic [63:0] data; bit ok; exp_t e;
      logic [63:0] rd_addr[4];
      logic [63:0] rd_exp[4];
      logic [1:0]  rd_resp[4];
      exp_q.push_back('{SLVERR, 64'h0});
      do_read(BASE + 64'h8000, resp, data, ok);
      e = exp_q.pop_front();
      n_cmp++;
      if (!ok || resp !== e.resp || data !== e.data) begin
         n_err++; $display("FAIL unmapped_rd: got ok=%0d resp=%0d data=%h want resp=%0d data=%h", ok, resp, data, e.resp, e.data);
      end
      exp_q.push_back('{SLVERR, 64'h0});
      do_write(BASE + 64'hC0010, ONES, 8'hFF, resp, ok);
      e = exp_q.pop_front();
      n_cmp++;
      if (!ok || resp !== e.resp) begin
         n_err++; $display("FAIL unmapped_wr: got ok=%0d resp=%0d want resp=%0d", ok, resp, e.resp);
      end
      exp_q.push_back('{SLVERR, 64'h0});
      do_write(BASE + 64'h4, 64'h0, 8'hFF, resp, ok);
      e = exp_q.pop_front();
      n_cmp++;
      if (!ok || resp !== e.resp) begin
         n_err++; $display("FAIL msip_hart1_wr: got ok=%0d resp=%0d want resp=%0d", ok, resp, e.resp);
      end
      rd_addr[0] = BASE + 64'hBFF8;  rd_exp[0] = 64'h12AB; rd_resp[0] = OKAY;
      rd_addr[1] = BASE + 64'h4000;  rd_exp[1] = 64'd100;  rd_resp[1] = OKAY;
      rd_addr[2] = BASE;             rd_exp[2] = 64'h1;    rd_resp[2] = OKAY;
      rd_addr[3] = BASE + 64'hCBFF8; rd_exp[3] = 64'h0;    rd_resp[3] = SLVERR;
      for (int i = 0; i < 4; i++) begin
         exp_q.push_back('{rd_resp[i], rd_exp[i]});
         do_read(rd_addr[i], resp, data, ok);
         e = exp_q.pop_front();
         n_cmp++;
         if (!ok || resp !== e.resp || data !== e.data) begin
            n_err++; $display("FAIL slverr_nochange[%0d]: got ok=%0d resp=%0d data=%h want resp=%0d data=%h", i, ok, resp, data, e.resp, e.data);
         end
      end
   endtask

   task automatic test_collision;
      logic [1:0] resp; logic [63:0] data; bit ok; exp_t e;
      @(negedge clk);
      aw_addr = BASE + 64'h4000; w_data = 64'h55; w_strb = 8'hFF; aw_valid = 1'b1; w_valid = 1'b1;
      ar_addr = BASE + 64'h4000; ar_valid = 1'b1;
      exp_q.push_back('{OKAY, 64'd100});
      #1;
      n_cmp++;
      if (aw_ready !== 1'b1 || ar_ready !== 1'b1) begin
         n_err++; $display("FAIL coll_accept: got aw=%b ar=%b want 1 1", aw_ready, ar_ready);
      end
      @(posedge clk); #1;
      aw_valid = 1'b0; w_valid = 1'b0; ar_valid = 1'b0;
      @(negedge clk);
      e = exp_q.pop_front();
      n_cmp++;
      if (r_valid !== 1'b1 || b_valid !== 1'b1 || r_resp !== e.resp || r_data !== e.data) begin
         n_err++; $display("FAIL coll_pre_write: got rv=%b bv=%b resp=%0d data=%h want 1 1 %0d %h", r_valid, b_valid, r_resp, r_data, e.resp, e.data);
      end
      exp_q.push_back('{OKAY, 64'h55});
      do_read(BASE + 64'h4000, resp, data, ok);
      e = exp_q.pop_front();
      n_cmp++;
      if (!ok || resp !== e.resp || data !== e.data) begin
         n_err++; $display("FAIL coll_post_write: got ok=%0d resp=%0d data=%h want data=%h", ok, resp, data, e.data);
      end
   endtask

   task automatic test_back_to_back;
      logic [1:0] resp; logic [63:0] data; bit ok; exp_t e;
      b_ready = 1'b0;
      @(negedge clk);
      aw_addr = BASE + 64'h4000; w_data = 64'h77; w_strb = 8'hFF; aw_valid = 1'b1; w_valid = 1'b1;
      exp_q.push_back('{OKAY, 64'h0});
      #1;
      n_cmp++;
      if (aw_ready !== 1'b1) begin
         n_err++; $display("FAIL b2b_first_accept: got %b want 1", aw_ready);
      end
      @(posedge clk); #1;
      aw_addr = BASE; w_data = 64'h0; w_strb = 8'h0F;
      e = exp_q.pop_front();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_cmp++;
         if (b_valid !== 1'b1 || b_resp !== e.resp || aw_ready !== 1'b0 || w_ready !== 1'b0) begin
            n_err++; $display("FAIL b2b_stall[%0d]: got bv=%b resp=%0d awr=%b wr=%b want 1 %0d 0 0", i, b_valid, b_resp, aw_ready, w_ready, e.resp);
         end
      end
      b_ready = 1'b1;
      exp_q.push_back('{OKAY, 64'h0});
      @(posedge clk); #1;
      n_cmp++;
      if (aw_ready !== 1'b1 || b_valid !== 1'b0) begin
         n_err++; $display("FAIL b2b_second_accept: got awr=%b bv=%b want 1 0", aw_ready, b_valid);
      end
      @(posedge clk); #1;
      aw_valid = 1'b0; w_valid = 1'b0;
      @(negedge clk);
      e = exp_q.pop_front();
      n_cmp++;
      if (b_valid !== 1'b1 || b_resp !== e.resp) begin
         n_err++; $display("FAIL b2b_second_b: got bv=%b resp=%0d want 1 %0d", b_valid, b_resp, e.resp);
      end
      exp_q.push_back('{OKAY, 64'h77});
      do_read(BASE + 64'h4000, resp, data, ok);
      e = exp_q.pop_front();
      n_cmp++;
      if (!ok || resp !== e.resp || data !== e.data) begin
         n_err++; $display("FAIL b2b_rd_cmp: got ok=%0d resp=%0d data=%h want data=%h", ok, resp, data, e.data);
      end
      exp_q.push_back('{OKAY, 64'h0});
      do_read(BASE, resp, data, ok);
      e = exp_q.pop_front();
      n_cmp++;
      if (!ok || resp !== e.resp || data !== e.data) begin
         n_err++; $display("FAIL b2b_rd_msip: got ok=%0d resp=%0d data=%h want data=%h", ok, resp, data, e.data);
      end
   endtask

   task automatic test_reset_mid;
      logic [1:0] resp; logic [63:0] data; bit ok; exp_t e;
      logic [63:0] rd_addr[3];
      logic [63:0] rd_exp[3];
      do_write(BASE, 64'h1, 8'h0F, resp, ok);
      b_ready = 1'b0; r_ready = 1'b0;
      @(negedge clk);
      aw_addr = BASE + 64'h4000; w_data = 64'h99; w_strb = 8'hFF; aw_valid = 1'b1; w_valid = 1'b1;
      ar_addr = BASE + 64'hBFF8; ar_valid = 1'b1;
      @(posedge clk); #1;
      aw_valid = 1'b0; w_valid = 1'b0; ar_valid = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (b_valid !== 1'b1 || r_valid !== 1'b1 || ipi[0] !== 1'b1) begin
         n_err++; $display("FAIL mid_pending: got bv=%b rv=%b ipi=%b want 1 1 1", b_valid, r_valid, ipi[0]);
      end
      rst_n = 1'b0;
      @(posedge clk); #1 rst_n = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (b_valid !== 1'b0 || r_valid !== 1'b0 || ipi[0] !== 1'b0 || r_data !== 64'h0) begin
         n_err++; $display("FAIL mid_dropped: got bv=%b rv=%b ipi=%b data=%h want 0 0 0 0", b_valid, r_valid, ipi[0], r_data);
      end
      b_ready = 1'b1; r_ready = 1'b1;
      rd_addr[0] = BASE + 64'h4000; rd_exp[0] = ONES;
      rd_addr[1] = BASE + 64'hBFF8; rd_exp[1] = 64'h0;
      rd_addr[2] = BASE;            rd_exp[2] = 64'h0;
      for (int i = 0; i < 3; i++) begin
         exp_q.push_back('{OKAY, rd_exp[i]});
         do_read(rd_addr[i], resp, data, ok);
         e = exp_q.pop_front();
         n_cmp++;
         if (!ok || resp !== e.resp || data !== e.data) begin
            n_err++; $display("FAIL mid_reg_reset[%0d]: got ok=%0d resp=%0d data=%h want data=%h", i, ok, resp, data, e.data);
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n = 1'b0; rtc = 1'b0;
      aw_addr = '0; aw_valid = 1'b0; w_data = '0; w_strb = '0; w_valid = 1'b0; b_ready = 1'b1;
      ar_addr = '0; ar_valid = 1'b0; r_ready = 1'b1;
      test_reset();
      test_msip();
      test_timer();
      test_mtime();
      test_slverr();
      test_collision();
      test_back_to_back();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
